// File: rtl/attempt_monitor.sv
// attempt_monitor
//   Downstream observer of the key checker. Measures how many cycles each
//   compare takes (the timing-leak observable), shows the result on two LEDs
//   for a hold period, re-arms the checker with a one-cycle restart pulse and
//   locks the checker out after MAX_FAILS consecutive failed attempts.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   in_compare     checker is in its compare state
//   success        checker compare matched
//   fail           checker compare mismatched
//   checker_rst    restart request to the checker (OR'd with rst outside)
//   led_success    last attempt succeeded (lit during SHOW)
//   led_fail       last attempt failed (lit during SHOW and LOCKED)
//   compare_cycles cycle count of the last completed compare
//   fail_count     consecutive failed attempts, saturating at 255
//   locked         lockout active
//   dbg_state      current FSM state (IDLE=0 MEASURE=1 SHOW=2 RESTART=3 LOCKED=4)
//
// Handshake: the checker inputs are level signals sampled on every rising
// edge; a result is taken on any edge where success|fail is high while in
// IDLE (with in_compare) or MEASURE, and ignored in all other states.
module attempt_monitor #(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int HOLD_MS       = 1000,
    parameter int MAX_FAILS     = 8,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_compare,
    input  logic                 success,
    input  logic                 fail,
    output logic                 checker_rst,
    output logic                 led_success,
    output logic                 led_fail,
    output logic [CNT_WIDTH-1:0] compare_cycles,
    output logic [7:0]           fail_count,
    output logic                 locked,
    output logic [2:0]           dbg_state
);

    localparam int HOLD_RAW    = CLK_FREQUENCY / 1000 * HOLD_MS;
    localparam int HOLD_CYCLES = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
    localparam int HOLD_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [7:0]           FAIL_LIM  = 8'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEASURE = 3'd1,
        S_SHOW    = 3'd2,
        S_RESTART = 3'd3,
        S_LOCKED  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [CNT_WIDTH-1:0]   compare_cycles_q, compare_cycles_d;
    logic [7:0]             fail_count_q, fail_count_d;
    logic                   led_success_q, led_success_d;
    logic                   led_fail_q, led_fail_d;
    logic                   checker_rst_q, checker_rst_d;
    logic                   locked_q, locked_d;

    logic                   result;
    logic                   do_latch;
    logic [CNT_WIDTH-1:0]   latch_val;
    logic [CNT_WIDTH-1:0]   count_inc;
    logic [7:0]             fail_inc;

    assign result    = success | fail;
    // Both counters saturate instead of wrapping.
    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
    assign fail_inc  = (fail_count_q == 8'hff) ? fail_count_q : fail_count_q + 8'd1;

    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        hold_d           = hold_q;
        compare_cycles_d = compare_cycles_q;
        fail_count_d     = fail_count_q;
        led_success_d    = led_success_q;
        led_fail_d       = led_fail_q;
        checker_rst_d    = 1'b0;
        locked_d         = locked_q;
        do_latch         = 1'b0;
        latch_val        = count_q;

        case (state_q)
            S_IDLE: begin
                if (in_compare) begin
                    if (result) begin
                        // Result in the very first compare cycle: duration 1.
                        do_latch  = 1'b1;
                        latch_val = CNT_ONE;
                    end else begin
                        count_d = CNT_ONE;
                        state_d = S_MEASURE;
                    end
                end
            end
            S_MEASURE: begin
                if (result) begin
                    // The result cycle itself counts as one compare cycle.
                    do_latch  = 1'b1;
                    latch_val = count_inc;
                end else if (in_compare) begin
                    count_d = count_inc;
                end else begin
                    // Compare abandoned without a verdict: nothing is latched.
                    state_d = S_IDLE;
                end
            end
            S_SHOW: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d        = '0;
                    checker_rst_d = 1'b1;
                    if (fail_count_q >= FAIL_LIM) begin
                        state_d       = S_LOCKED;
                        locked_d      = 1'b1;
                        led_fail_d    = 1'b1;
                        led_success_d = 1'b0;
                    end else begin
                        state_d       = S_RESTART;
                        led_fail_d    = 1'b0;
                        led_success_d = 1'b0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_RESTART: begin
                state_d = S_IDLE;
            end
            S_LOCKED: begin
                checker_rst_d = 1'b1;
                locked_d      = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_latch) begin
            state_d          = S_SHOW;
            hold_d           = '0;
            count_d          = '0;
            compare_cycles_d = latch_val;
            // success together with fail is treated as a fail.
            if (success && !fail) begin
                led_success_d = 1'b1;
                led_fail_d    = 1'b0;
                fail_count_d  = 8'd0;
            end else begin
                led_success_d = 1'b0;
                led_fail_d    = 1'b1;
                fail_count_d  = fail_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            count_q          <= '0;
            hold_q           <= '0;
            compare_cycles_q <= '0;
            fail_count_q     <= 8'd0;
            led_success_q    <= 1'b0;
            led_fail_q       <= 1'b0;
            checker_rst_q    <= 1'b0;
            locked_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            hold_q           <= hold_d;
            compare_cycles_q <= compare_cycles_d;
            fail_count_q     <= fail_count_d;
            led_success_q    <= led_success_d;
            led_fail_q       <= led_fail_d;
            checker_rst_q    <= checker_rst_d;
            locked_q         <= locked_d;
        end
    end

    assign checker_rst    = checker_rst_q;
    assign led_success    = led_success_q;
    assign led_fail       = led_fail_q;
    assign compare_cycles = compare_cycles_q;
    assign fail_count     = fail_count_q;
    assign locked         = locked_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_attempt_monitor.sv
module tb_attempt_monitor;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_compare = 1'b0, success = 1'b0, fail = 1'b0;
    logic checker_rst, led_success, led_fail, locked;
    logic [W-1:0] compare_cycles;
    logic [7:0] fail_count;
    logic [2:0] dbg_state;

    // Second instance with a 4-bit counter for the saturation check.
    logic in_compare2 = 1'b0, success2 = 1'b0, fail2 = 1'b0;
    logic checker_rst2, led_success2, led_fail2, locked2;
    logic [3:0] compare_cycles2;
    logic [7:0] fail_count2;
    logic [2:0] dbg_state2;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_MEAS = 3'd1, ST_SHOW = 3'd2,
                           ST_RESTART = 3'd3, ST_LOCKED = 3'd4;

    always #5 clk = ~clk;

    attempt_monitor #(.CLK_FREQUENCY(1000), .HOLD_MS(4), .MAX_FAILS(3), .CNT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_compare(in_compare), .success(success), .fail(fail),
        .checker_rst(checker_rst), .led_success(led_success), .led_fail(led_fail),
        .compare_cycles(compare_cycles), .fail_count(fail_count), .locked(locked),
        .dbg_state(dbg_state)
    );

    attempt_monitor #(.CLK_FREQUENCY(1000), .HOLD_MS(4), .MAX_FAILS(3), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .in_compare(in_compare2), .success(success2), .fail(fail2),
        .checker_rst(checker_rst2), .led_success(led_success2), .led_fail(led_fail2),
        .compare_cycles(compare_cycles2), .fail_count(fail_count2), .locked(locked2),
        .dbg_state(dbg_state2)
    );

    // Advance one clock; inputs driven after this return are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_compare = 1'b0; success = 1'b0; fail = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // in_compare high for n cycles, verdict in the last one; returns right after
    // the edge that latched the verdict (first SHOW cycle).
    task automatic run_attempt(input int n, input logic s, input logic f);
        for (int i = 1; i <= n; i++) begin
            in_compare = 1'b1;
            success = (i == n) ? s : 1'b0;
            fail    = (i == n) ? f : 1'b0;
            step();
        end
        in_compare = 1'b0; success = 1'b0; fail = 1'b0;
    endtask

    // From the first SHOW cycle, run through SHOW and RESTART back to IDLE.
    task automatic finish_show();
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({checker_rst, led_success, led_fail, locked} !== 4'b0 || compare_cycles !== 16'd0 ||
            fail_count !== 8'd0 || dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset: rst=%b ls=%b lf=%b lk=%b cc=%0d fc=%0d st=%0d, expected all 0",
                     checker_rst, led_success, led_fail, locked, compare_cycles, fail_count, dbg_state);
        end
    endtask

    task automatic test_success_timing();
        run_attempt(5, 1'b1, 1'b0);
        n_cmp++;
        if (compare_cycles !== 16'd5 || led_success !== 1'b1 || led_fail !== 1'b0 ||
            fail_count !== 8'd0 || dbg_state !== ST_SHOW) begin
            n_err++;
            $display("FAIL success_latch: cc=%0d ls=%b lf=%b fc=%0d st=%0d, expected 5 1 0 0 2",
                     compare_cycles, led_success, led_fail, fail_count, dbg_state);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (led_success !== 1'b1 || checker_rst !== 1'b0) begin
                n_err++;
                $display("FAIL success_hold[%0d]: ls=%b crst=%b, expected 1 0", i, led_success, checker_rst);
            end
            step();
        end
        n_cmp++;
        if (checker_rst !== 1'b1 || led_success !== 1'b0 || dbg_state !== ST_RESTART) begin
            n_err++;
            $display("FAIL success_restart: crst=%b ls=%b st=%0d, expected 1 0 3",
                     checker_rst, led_success, dbg_state);
        end
        step();
        n_cmp++;
        if (checker_rst !== 1'b0 || dbg_state !== ST_IDLE || compare_cycles !== 16'd5) begin
            n_err++;
            $display("FAIL success_idle: crst=%b st=%0d cc=%0d, expected 0 0 5",
                     checker_rst, dbg_state, compare_cycles);
        end
    endtask

    task automatic test_fail_then_success();
        run_attempt(3, 1'b0, 1'b1);
        n_cmp++;
        if (compare_cycles !== 16'd3 || fail_count !== 8'd1 || led_fail !== 1'b1 || led_success !== 1'b0) begin
            n_err++;
            $display("FAIL fail_latch: cc=%0d fc=%0d lf=%b ls=%b, expected 3 1 1 0",
                     compare_cycles, fail_count, led_fail, led_success);
        end
        finish_show();
        run_attempt(7, 1'b1, 1'b0);
        n_cmp++;
        if (compare_cycles !== 16'd7 || fail_count !== 8'd0 || led_success !== 1'b1 || led_fail !== 1'b0) begin
            n_err++;
            $display("FAIL success_after_fail: cc=%0d fc=%0d ls=%b lf=%b, expected 7 0 1 0",
                     compare_cycles, fail_count, led_success, led_fail);
        end
        finish_show();
    endtask

    task automatic test_both_and_abort();
        run_attempt(2, 1'b1, 1'b1);
        n_cmp++;
        if (compare_cycles !== 16'd2 || fail_count !== 8'd1 || led_fail !== 1'b1 || led_success !== 1'b0) begin
            n_err++;
            $display("FAIL both_is_fail: cc=%0d fc=%0d lf=%b ls=%b, expected 2 1 1 0",
                     compare_cycles, fail_count, led_fail, led_success);
        end
        finish_show();
        // Abort: four cycles of in_compare with no verdict.
        for (int i = 0; i < 4; i++) begin
            in_compare = 1'b1;
            step();
        end
        in_compare = 1'b0;
        step();
        n_cmp++;
        if (dbg_state !== ST_IDLE || compare_cycles !== 16'd2 || fail_count !== 8'd1 ||
            led_fail !== 1'b0 || led_success !== 1'b0) begin
            n_err++;
            $display("FAIL abort: st=%0d cc=%0d fc=%0d lf=%b ls=%b, expected 0 2 1 0 0",
                     dbg_state, compare_cycles, fail_count, led_fail, led_success);
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (checker_rst !== 1'b0) begin
                n_err++;
                $display("FAIL abort_no_restart[%0d]: crst=%b, expected 0", i, checker_rst);
            end
            step();
        end
    endtask

    task automatic test_lockout();
        do_reset();
        run_attempt(2, 1'b0, 1'b1);
        finish_show();
        run_attempt(4, 1'b0, 1'b1);
        finish_show();
        run_attempt(3, 1'b0, 1'b1);
        n_cmp++;
        if (fail_count !== 8'd3 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL third_fail: fc=%0d lk=%b, expected 3 0", fail_count, locked);
        end
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 120; i++) begin
            n_cmp++;
            if (locked !== 1'b1 || checker_rst !== 1'b1 || led_fail !== 1'b1 ||
                led_success !== 1'b0 || dbg_state !== ST_LOCKED) begin
                n_err++;
                $display("FAIL locked[%0d]: lk=%b crst=%b lf=%b ls=%b st=%0d, expected 1 1 1 0 4",
                         i, locked, checker_rst, led_fail, led_success, dbg_state);
            end
            in_compare = (i % 2 == 0);
            success    = (i % 3 == 0);
            fail       = (i % 5 == 0);
            step();
        end
        n_cmp++;
        if (compare_cycles !== 16'd3 || fail_count !== 8'd3) begin
            n_err++;
            $display("FAIL locked_frozen: cc=%0d fc=%0d, expected 3 3", compare_cycles, fail_count);
        end
        do_reset();
        n_cmp++;
        if (locked !== 1'b0 || fail_count !== 8'd0 || checker_rst !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL unlock: lk=%b fc=%0d crst=%b st=%0d, expected 0 0 0 0",
                     locked, fail_count, checker_rst, dbg_state);
        end
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 30; i++) begin
            in_compare2 = 1'b1;
            fail2 = (i == 30);
            step();
        end
        in_compare2 = 1'b0; fail2 = 1'b0;
        n_cmp++;
        if (compare_cycles2 !== 4'd15 || led_fail2 !== 1'b1 || fail_count2 !== 8'd1) begin
            n_err++;
            $display("FAIL saturation: cc=%0d lf=%b fc=%0d, expected 15 1 1",
                     compare_cycles2, led_fail2, fail_count2);
        end
    endtask

    task automatic test_reset_mid_show();
        run_attempt(6, 1'b1, 1'b0);
        step();
        n_cmp++;
        if (dbg_state !== ST_SHOW || led_success !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_show: st=%0d ls=%b, expected 2 1", dbg_state, led_success);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({checker_rst, led_success, led_fail, locked} !== 4'b0 || compare_cycles !== 16'd0 ||
            fail_count !== 8'd0 || dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_mid_show: crst=%b ls=%b lf=%b lk=%b cc=%0d fc=%0d st=%0d, expected all 0",
                     checker_rst, led_success, led_fail, locked, compare_cycles, fail_count, dbg_state);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (checker_rst !== 1'b0 || dbg_state !== ST_IDLE) begin
                n_err++;
                $display("FAIL after_reset_idle[%0d]: crst=%b st=%0d, expected 0 0", i, checker_rst, dbg_state);
            end
        end
    endtask

    initial begin
        test_reset();
        test_success_timing();
        test_fail_then_success();
        test_both_and_abort();
        test_lockout();
        test_saturation();
        test_reset_mid_show();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
